reg_file: RTL

- Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer.
- Consumes ROB commit outputs (rd, value, ROB id) to update architectural state.
- Gets rd and ROB tail from the instruction unit at issue, and marks the destination register as pending on that ROB entry.
- Serves two combinational operand lookups to the issue logic (value, or the producing ROB id if pending); flushes all tags on ROB clear.

---
 rtl/reg_file.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: architectural register file with per-register rename tags.
//
// Holds the committed value of each architectural register plus a
// busy/dep tag naming the in-flight ROB entry that will produce it.
// Sits directly downstream of the reorder buffer.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    low = pause; all state holds
//   clear_in                  ROB flush: drop every tag, ignore issue
//   iss_req/iss_rd/iss_rob_id issue: mark iss_rd pending on iss_rob_id
//   cmt_rd/cmt_val/cmt_rob_id commit: write value, release tag if owner
//   rs1/rs2                   operand indices
//   rsN_val/rsN_busy/rsN_dep  combinational operand lookups
//
// Optional build macro RF_CMT_BYPASS_EN: forward a same-cycle commit onto
// the read ports, so a waiting operand sees the value without the extra
// cycle through storage.
// ---------------------------------------------------------------------------

// One operand read port: resolves storage (plus optional forward) into
// value / busy / dep.
module reg_file_rd_port #(
    parameter int ROB_IDX_W = 4
) (
    input  logic [4:0]           rs,
    input  logic [31:0]          st_val,
    input  logic                 st_busy,
    input  logic [ROB_IDX_W-1:0] st_dep,
    input  logic                 fwd,
    input  logic [31:0]          fwd_val,
    output logic [31:0]          rd_val,
    output logic                 rd_busy,
    output logic [ROB_IDX_W-1:0] rd_dep
);
    always_comb begin
        rd_val  = '0;
        rd_busy = 1'b0;
        rd_dep  = '0;
        if (rs == 5'd0) begin
            // x0 reads as zero regardless of storage
        end else if (fwd) begin
            rd_val = fwd_val;
        end else if (st_busy) begin
            rd_busy = 1'b1;
            rd_dep  = st_dep;
        end else begin
            rd_val = st_val;
        end
    end
endmodule

module reg_file #(
    parameter int ROB_IDX_W = 4,
    parameter int NREG      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 iss_req,
    input  logic [4:0]           iss_rd,
    input  logic [ROB_IDX_W-1:0] iss_rob_id,
    input  logic [4:0]           cmt_rd,
    input  logic [31:0]          cmt_val,
    input  logic [ROB_IDX_W-1:0] cmt_rob_id,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic [31:0]          rs1_val,
    output logic                 rs1_busy,
    output logic [ROB_IDX_W-1:0] rs1_dep,
    output logic [31:0]          rs2_val,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs2_dep
);
    localparam int NPORT = 2;

    logic [NREG-1:0][31:0]          val_q;
    logic [NREG-1:0]                busy_q;
    logic [NREG-1:0][ROB_IDX_W-1:0] dep_q;

    // Commit releases the tag only if this ROB entry is still the owner;
    // otherwise a younger issue has re-tagged the register.
    logic cmt_own;
    assign cmt_own = (cmt_rd != 5'd0) && busy_q[cmt_rd] && (dep_q[cmt_rd] == cmt_rob_id);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            val_q  <= '0;
            busy_q <= '0;
            dep_q  <= '0;
        end else if (rdy_in) begin
            // Committed values are architectural, so they land even on flush.
            if (cmt_rd != 5'd0)
                val_q[cmt_rd] <= cmt_val;
            if (clear_in) begin
                busy_q <= '0;
                dep_q  <= '0;
            end else begin
                if (cmt_own) begin
                    busy_q[cmt_rd] <= 1'b0;
                    dep_q[cmt_rd]  <= '0;
                end
                // Placed after the release so a same-rd issue wins the tag.
                if (iss_req && iss_rd != 5'd0) begin
                    busy_q[iss_rd] <= 1'b1;
                    dep_q[iss_rd]  <= iss_rob_id;
                end
            end
        end
    end

    logic [NPORT-1:0][4:0]           rs_idx;
    logic [NPORT-1:0]                fwd;
    logic [NPORT-1:0][31:0]          rd_val;
    logic [NPORT-1:0]                rd_busy;
    logic [NPORT-1:0][ROB_IDX_W-1:0] rd_dep;

    assign rs_idx = {rs2, rs1};

    for (genvar g = 0; g < NPORT; g++) begin : g_port
`ifdef RF_CMT_BYPASS_EN
        assign fwd[g] = rdy_in && !clear_in && (rs_idx[g] != 5'd0) &&
                        (rs_idx[g] == cmt_rd) && busy_q[rs_idx[g]] &&
                        (dep_q[rs_idx[g]] == cmt_rob_id);
`else
        assign fwd[g] = 1'b0;
`endif
        reg_file_rd_port #(.ROB_IDX_W(ROB_IDX_W)) u_port (
            .rs      (rs_idx[g]),
            .st_val  (val_q[rs_idx[g]]),
            .st_busy (busy_q[rs_idx[g]]),
            .st_dep  (dep_q[rs_idx[g]]),
            .fwd     (fwd[g]),
            .fwd_val (cmt_val),
            .rd_val  (rd_val[g]),
            .rd_busy (rd_busy[g]),
            .rd_dep  (rd_dep[g])
        );
    end

    assign rs1_val  = rd_val[0];
    assign rs1_busy = rd_busy[0];
    assign rs1_dep  = rd_dep[0];
    assign rs2_val  = rd_val[1];
    assign rs2_busy = rd_busy[1];
    assign rs2_dep  = rd_dep[1];
endmodule
